// File: rtl/result_fifo.sv
// Capture FIFO for adder results: queues valid (addr, result) pairs and drains them over
// valid/ready, with sticky flags for dropped pushes and breaks in the address sequence.
module result_fifo #(
  parameter  int MEM_WIDTH  = 32,
  parameter  int MEM_DEPTH  = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(MEM_DEPTH),
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 result_valid_i,
  input  logic [MEM_WIDTH-1:0] result_i,
  input  logic [AW-1:0]        result_addr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [MEM_WIDTH-1:0] out_result_o,
  output logic [AW-1:0]        out_addr_o,
  output logic [CW-1:0]        count_o,
  output logic                 overflow_o,
  output logic                 addr_gap_o,
  input  logic                 clear_i
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [MEM_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        addr_mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          gap_q, gap_d;
  logic [AW-1:0] exp_addr_q, exp_addr_d;
  logic          seen_q, seen_d;

  logic full, push, pop, wr_en;

  // Address successor modulo MEM_DEPTH, so the top-to-zero wrap is treated as in sequence.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    if (a == AW'(MEM_DEPTH - 1)) return '0;
    return a + AW'(1);
  endfunction

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = (count_q != '0) && out_ready_i;
  assign push  = result_valid_i && (!full || pop);
  assign wr_en = push && !clear_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    gap_d      = gap_q;
    exp_addr_d = exp_addr_q;
    seen_d     = seen_q;
    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      gap_d      = 1'b0;
      seen_d     = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      if (result_valid_i && !push) overflow_d = 1'b1;
      // Dropped inputs still advance the sequence check.
      if (result_valid_i) begin
        if (seen_q && (result_addr_i != exp_addr_q)) gap_d = 1'b1;
        exp_addr_d = next_addr(result_addr_i);
        seen_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      gap_q      <= 1'b0;
      exp_addr_q <= '0;
      seen_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      gap_q      <= gap_d;
      exp_addr_q <= exp_addr_d;
      seen_q     <= seen_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      data_mem_q[wr_ptr_q] <= result_i;
      addr_mem_q[wr_ptr_q] <= result_addr_i;
    end
  end

  assign out_valid_o  = (count_q != '0);
  assign out_result_o = data_mem_q[rd_ptr_q];
  assign out_addr_o   = addr_mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign addr_gap_o   = gap_q;

endmodule

// File: tb/tb_result_fifo.sv
// Directed bench for result_fifo: vector table for drain/overflow/full-swap/gap/clear,
// plus hand-written streaming-wrap and asynchronous-reset sequences.
module tb_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        result_valid = 1'b0;
  logic [31:0] result = '0;
  logic [2:0]  result_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0]  out_addr;
  logic [2:0]  count;
  logic        overflow;
  logic        addr_gap;
  logic        clear = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  result_fifo #(.MEM_WIDTH(32), .MEM_DEPTH(8), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .result_valid_i(result_valid), .result_i(result), .result_addr_i(result_addr),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_result_o(out_result), .out_addr_o(out_addr),
    .count_o(count), .overflow_o(overflow), .addr_gap_o(addr_gap),
    .clear_i(clear)
  );

  typedef struct {
    logic        v;
    logic [2:0]  a;
    logic [31:0] d;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [2:0]  ea;
    logic [31:0] ed;
    logic [2:0]  ec;
    logic        eo;
    logic        eg;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [2:0] a, logic [31:0] d, logic rdy, logic clr,
                              logic ev, logic [2:0] ea, logic [31:0] ed, logic [2:0] ec,
                              logic eo, logic eg);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.rdy = rdy; r.clr = clr;
    r.ev = ev; r.ea = ea; r.ed = ed; r.ec = ec; r.eo = eo; r.eg = eg;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [2:0] a, input logic [31:0] d,
                      input logic rdy, input logic clr);
    result_valid = v; result_addr = a; result = d; out_ready = rdy; clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic ev, input logic [2:0] ea,
                           input logic [31:0] ed, input logic [2:0] ec,
                           input logic eo, input logic eg);
    chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
    if (ev) begin
      chk({tag, ".addr"}, 32'(out_addr), 32'(ea));
      chk({tag, ".result"}, out_result, ed);
    end
    chk({tag, ".count"}, 32'(count), 32'(ec));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
    chk({tag, ".gap"}, 32'(addr_gap), 32'(eg));
  endtask

  initial begin
    // 3 pushes with ready low, then drain
    tbl.push_back(mk(1, 0, 32'h10, 0, 0, 1, 0, 32'h10, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'h20, 0, 0, 1, 0, 32'h10, 2, 0, 0));
    tbl.push_back(mk(1, 2, 32'h30, 0, 0, 1, 0, 32'h10, 3, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 1, 1, 32'h20, 2, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 1, 2, 32'h30, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0, 0));
    // fill 4, drop a 5th, drain the original four
    tbl.push_back(mk(1, 3, 32'hA3, 0, 0, 1, 3, 32'hA3, 1, 0, 0));
    tbl.push_back(mk(1, 4, 32'hA4, 0, 0, 1, 3, 32'hA3, 2, 0, 0));
    tbl.push_back(mk(1, 5, 32'hA5, 0, 0, 1, 3, 32'hA3, 3, 0, 0));
    tbl.push_back(mk(1, 6, 32'hA6, 0, 0, 1, 3, 32'hA3, 4, 0, 0));
    tbl.push_back(mk(1, 7, 32'hEE, 0, 0, 1, 3, 32'hA3, 4, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 1, 4, 32'hA4, 3, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 1, 5, 32'hA5, 2, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 1, 6, 32'hA6, 1, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  0, 1, 0));
    tbl.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  0, 0, 0));
    // full FIFO with simultaneous push and pop
    tbl.push_back(mk(1, 0, 32'hB0, 0, 0, 1, 0, 32'hB0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 32'hB1, 0, 0, 1, 0, 32'hB0, 2, 0, 0));
    tbl.push_back(mk(1, 2, 32'hB2, 0, 0, 1, 0, 32'hB0, 3, 0, 0));
    tbl.push_back(mk(1, 3, 32'hB3, 0, 0, 1, 0, 32'hB0, 4, 0, 0));
    tbl.push_back(mk(1, 4, 32'hB4, 1, 0, 1, 1, 32'hB1, 4, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 1, 2, 32'hB2, 3, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 1, 3, 32'hB3, 2, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 1, 4, 32'hB4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  0, 0, 0));
    // address gap 2 -> 5, sticky until clear
    tbl.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  0, 0, 0));
    tbl.push_back(mk(1, 2, 32'hC2, 1, 0, 1, 2, 32'hC2, 1, 0, 0));
    tbl.push_back(mk(1, 5, 32'hC5, 1, 0, 1, 5, 32'hC5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,  0, 0, 1, 5, 32'hC5, 1, 0, 1));
    tbl.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 32'h0,  0, 0, 0));

    // reset state
    #12;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.count", 32'(count), 32'd0);
    chk("reset.overflow", 32'(overflow), 32'd0);
    chk("reset.gap", 32'(addr_gap), 32'd0);
    chk("reset.result", out_result, 32'd0);
    chk("reset.addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk_state($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].ec,
                tbl[i].eo, tbl[i].eg);
    end

    // streaming 0..7 then 0 with ready high; wrap is not a gap
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 3'(i % 8), 32'h100 + 32'(i), 1'b1, 1'b0);
      chk_state($sformatf("stream%0d", i), 1'b1, 3'(i % 8), 32'h100 + 32'(i), 3'd1, 1'b0, 1'b0);
    end
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    chk_state("stream.end", 1'b0, 3'd0, 32'h0, 3'd0, 1'b0, 1'b0);

    // asynchronous reset with 2 entries queued
    step(1'b1, 3'd1, 32'h51, 1'b0, 1'b0);
    step(1'b1, 3'd2, 32'h52, 1'b0, 1'b0);
    chk_state("prerst", 1'b1, 3'd1, 32'h51, 3'd2, 1'b0, 1'b0);
    result_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.result", out_result, 32'd0);
    chk("arst.addr", 32'(out_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd3, 32'h53, 1'b0, 1'b0);
    chk_state("resume0", 1'b1, 3'd3, 32'h53, 3'd1, 1'b0, 1'b0);
    step(1'b1, 3'd4, 32'h54, 1'b0, 1'b0);
    chk_state("resume1", 1'b1, 3'd3, 32'h53, 3'd2, 1'b0, 1'b0);
    step(1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    chk_state("resume2", 1'b1, 3'd4, 32'h54, 3'd1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
